// File: rtl/cdc_handshake_tx.sv
// -----------------------------------------------------------------------------
// cdc_handshake_tx
//
// This is the sending end of a 4-phase req/ack clock-domain-crossing handshake.
// A word is captured on an accepted send_i pulse and held on data_o. The block
// then raises req_o and waits for the far side's ack. The asynchronous ack_i
// passes through a SYNC_STAGES-deep flop chain first. After the return-to-zero
// phase, done_o pulses for one cycle.
//
// Optional feature (compile-time macro CDC_TIMEOUT_EN):
//   Each handshake phase gets a watchdog of TIMEOUT cycles. When it expires,
//   the transfer is aborted and err_o pulses. Without the macro, err_o is tied
//   to 0 and the block waits indefinitely.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous, active-high reset
//   send_i     one-cycle request to transfer data_i
//   data_i     word to transfer, sampled only in the accept cycle
//   ready_o    high while idle; send_i is accepted only then
//   req_o      handshake request level, straight from a flop
//   data_o     held word; stable from req_o rise until return to idle
//   ack_i      asynchronous acknowledge from the far domain
//   done_o     one-cycle pulse on transfer completion
//   overrun_o  one-cycle pulse when send_i arrives while not ready
//   err_o      one-cycle timeout pulse (0 without CDC_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module cdc_handshake_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic             done_o,
  output logic             overrun_o,
  output logic             err_o
);

  // Reject illegal configurations at elaboration time.
  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("cdc_handshake_tx: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                 state_r;
  logic [SYNC_STAGES-1:0] ack_sync_r;
  logic                   ack_s;
  logic                   req_r;
  logic                   ready_r;
  logic [WIDTH-1:0]       data_r;
  logic                   done_r;
  logic                   overrun_r;
  logic                   tmo_hit_s;

`ifdef CDC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_inc_s;
  logic          err_r;

  // Saturating next count; the phase has expired when it reaches TIMEOUT.
  always_comb begin
    cnt_inc_s = cnt_r;
    tmo_hit_s = 1'b0;
    if (cnt_r == CW'(TIMEOUT)) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CW'(1);
    end
    tmo_hit_s = (cnt_inc_s == CW'(TIMEOUT));
  end

  assign err_o = err_r;
`else
  assign tmo_hit_s = 1'b0;
  assign err_o     = 1'b0;
`endif

  // ack_i resynchronizer; the FSM only ever looks at the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s = ack_sync_r[SYNC_STAGES-1];

  // Handshake FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      req_r     <= 1'b0;
      ready_r   <= 1'b1;
      data_r    <= {WIDTH{1'b0}};
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
`ifdef CDC_TIMEOUT_EN
      cnt_r     <= {CW{1'b0}};
      err_r     <= 1'b0;
`endif
    end else begin
      done_r    <= 1'b0;
      // A send while busy is dropped and only flagged.
      overrun_r <= send_i & ~ready_r;
`ifdef CDC_TIMEOUT_EN
      err_r     <= 1'b0;
      // Counter clears unless the phase continues (see increments below).
      cnt_r     <= {CW{1'b0}};
`endif
      case (state_r)
        ST_IDLE: begin
          if (send_i) begin
            data_r  <= data_i;
            req_r   <= 1'b1;
            ready_r <= 1'b0;
            state_r <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A stale ack already high on entry is taken as valid.
          if (ack_s) begin
            req_r   <= 1'b0;
            state_r <= ST_RELEASE;
          end else if (tmo_hit_s) begin
            req_r   <= 1'b0;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
`ifdef CDC_TIMEOUT_EN
            err_r   <= 1'b1;
`endif
          end else begin
`ifdef CDC_TIMEOUT_EN
            cnt_r   <= cnt_inc_s;
`endif
          end
        end
        ST_RELEASE: begin
          if (!ack_s) begin
            ready_r <= 1'b1;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else if (tmo_hit_s) begin
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
`ifdef CDC_TIMEOUT_EN
            err_r   <= 1'b1;
`endif
          end else begin
`ifdef CDC_TIMEOUT_EN
            cnt_r   <= cnt_inc_s;
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign req_o     = req_r;
  assign ready_o   = ready_r;
  assign data_o    = data_r;
  assign done_o    = done_r;
  assign overrun_o = overrun_r;

endmodule
